// File: rtl/safe_pkg.sv
// Shared constants for the safe dial datapath.
//   POS_W            width of the dial position
//   SEL_D0..SEL_NONE digit-select encodings driven by the master FSM
//   DIR_CW / DIR_CCW encoding of the 'up' direction flag
//   pos_next()       wrap-around position step
package safe_pkg;

  localparam int POS_W = 6;

  localparam logic [1:0] SEL_D0   = 2'd0;
  localparam logic [1:0] SEL_D1   = 2'd1;
  localparam logic [1:0] SEL_D2   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // One dial step with wrap in both directions over 0..pos_max.
  function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] pos,
                                                input logic             cw,
                                                input logic [POS_W-1:0] pos_max);
    logic [POS_W-1:0] nxt;
    if (cw == DIR_CW) nxt = (pos == pos_max) ? '0 : pos + POS_W'(1);
    else              nxt = (pos == '0) ? pos_max : pos - POS_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/safe_dial_if.sv
// Signal bundle between the safe master FSM / encoder pins and the dial datapath.
//   master : drives qa, qb (raw encoder pins), countEn, clrCount, sel, blank
//   slave  : drives cnten, up, dirch, eq, pos, disp_on
// Signalling: there is no valid/ready pair here. Inputs are levels sampled on
// every clk edge; cnten and dirch are single-cycle pulses that the consumer must
// accept in the cycle they are high (no back-pressure exists); up, eq, pos and
// disp_on are registered levels that hold until the next update.
interface safe_dial_if;
  import safe_pkg::*;

  logic             qa;
  logic             qb;
  logic             countEn;
  logic             clrCount;
  logic [1:0]       sel;
  logic             blank;
  logic             cnten;
  logic             up;
  logic             dirch;
  logic             eq;
  logic [POS_W-1:0] pos;
  logic             disp_on;

  modport master (
    output qa, qb, countEn, clrCount, sel, blank,
    input  cnten, up, dirch, eq, pos, disp_on
  );

  modport slave (
    input  qa, qb, countEn, clrCount, sel, blank,
    output cnten, up, dirch, eq, pos, disp_on
  );

endinterface

// File: rtl/safe_dial_quad_step.sv
// quad_step: turns the asynchronous encoder pins into single-cycle step strobes.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_qa, i_qb  raw quadrature pins
//   o_step      high for one cycle per rising edge of the conditioned qa
//   o_step_cw   direction of that step (conditioned qb low = clockwise)
// Build option SAFE_DIAL_DEBOUNCE_EN inserts a per-pin stability filter of
// DEB_CYC cycles after the synchronizers.
module quad_step #(
  parameter int DEB_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_qa,
  input  logic i_qb,
  output logic o_step,
  output logic o_step_cw
);

  // bit 0 = qa, bit 1 = qb
  logic [1:0] w_pin;
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] w_filt;
  logic       r_qa_d;

  assign w_pin = {i_qb, i_qa};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_pin;
      r_s2 <= r_s1;
    end
  end

`ifdef SAFE_DIAL_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [1:0]       r_filt;
  logic [CNT_W-1:0] r_cnt [2];

  // The filtered level follows the synced pin only after DEB_CYC consecutive
  // samples that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt   <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] != r_filt[i]) begin
          if (r_cnt[i] == CNT_W'(DEB_CYC - 1)) begin
            r_filt[i] <= r_s2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_qa_d <= 1'b0;
    else        r_qa_d <= w_filt[0];
  end

  assign o_step    = w_filt[0] & ~r_qa_d;
  assign o_step_cw = ~w_filt[1];

endmodule

// File: rtl/safe_dial.sv
// safe_dial: dial-side datapath feeding the safe master FSM.
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   safe_dial_if.slave: qa/qb pins, countEn, clrCount, sel, blank in;
//         cnten, up, dirch, eq, pos, disp_on out
// Tracks the dial position from encoder steps, flags direction reversals and
// compares the position against the combination digit chosen by sel.
// Build option SAFE_DIAL_DEBOUNCE_EN enables the pin debounce filter in quad_step.
module safe_dial
  import safe_pkg::*;
#(
  parameter int DIAL_MAX = 39,
  parameter int CODE0    = 10,
  parameter int CODE1    = 25,
  parameter int CODE2    = 5,
  parameter int DEB_CYC  = 8
) (
  input  logic          clk,
  input  logic          rst,
  safe_dial_if.slave    bus
);

  logic             w_step;
  logic             w_step_cw;
  logic [POS_W-1:0] w_code;
  logic             w_sel_ok;

  logic             r_cnten;
  logic             r_up;
  logic             r_dirch;
  logic             r_eq;
  logic [POS_W-1:0] r_pos;
  logic             r_disp_on;
  logic             r_has_dir;

  quad_step #(
    .DEB_CYC (DEB_CYC)
  ) u_quad_step (
    .clk       (clk),
    .rst_n     (rst),
    .i_qa      (bus.qa),
    .i_qb      (bus.qb),
    .o_step    (w_step),
    .o_step_cw (w_step_cw)
  );

  always_comb begin
    w_code   = '0;
    w_sel_ok = 1'b1;
    case (bus.sel)
      SEL_D0:  w_code = POS_W'(CODE0);
      SEL_D1:  w_code = POS_W'(CODE1);
      SEL_D2:  w_code = POS_W'(CODE2);
      default: w_sel_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnten   <= 1'b0;
      r_up      <= DIR_CW;
      r_dirch   <= 1'b0;
      r_eq      <= 1'b0;
      r_pos     <= '0;
      r_disp_on <= 1'b0;
      r_has_dir <= 1'b0;
    end else begin
      // Compare uses the position before any step/clear in this cycle, so on a
      // reversal eq still reports the digit that was dialed.
      r_eq      <= w_sel_ok && (r_pos == w_code);
      r_disp_on <= ~bus.blank;
      if (bus.clrCount) begin
        r_pos     <= '0;
        r_up      <= DIR_CW;
        r_has_dir <= 1'b0;
        r_cnten   <= 1'b0;
        r_dirch   <= 1'b0;
      end else if (w_step) begin
        r_cnten <= 1'b1;
        r_pos   <= pos_next(r_pos, w_step_cw, POS_W'(DIAL_MAX));
        r_up    <= w_step_cw;
        // In free mode reversals are not reported and history is frozen.
        r_dirch <= !bus.countEn && r_has_dir && (w_step_cw != r_up);
        if (!bus.countEn) r_has_dir <= 1'b1;
      end else begin
        r_cnten <= 1'b0;
        r_dirch <= 1'b0;
      end
    end
  end

  assign bus.cnten   = r_cnten;
  assign bus.up      = r_up;
  assign bus.dirch   = r_dirch;
  assign bus.eq      = r_eq;
  assign bus.pos     = r_pos;
  assign bus.disp_on = r_disp_on;

endmodule

// File: tb/tb_safe_dial.sv
module tb_safe_dial;
  import safe_pkg::*;

`ifdef SAFE_DIAL_DEBOUNCE_EN
  localparam int LAT  = 3 + 8;
  localparam int HOLD = 8 + 2;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  safe_dial_if bus();

  safe_dial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_cnten = 0;

  // Scheduled steps: {cw, edge number at which the step must be accepted}
  logic [32:0] exp_q[$];

  // Behavioural model of the observable outputs
  int   m_pos;
  logic m_up, m_has, m_cnten, m_dirch, m_eq, m_disp;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int code_of(input logic [1:0] s);
    case (s)
      2'd0:    return 10;
      2'd1:    return 25;
      2'd2:    return 5;
      default: return -1;
    endcase
  endfunction

  // Model update at each edge, compare 1 time unit later.
  always begin
    logic st, cw;
    @(posedge clk);
    cyc++;
    st = 1'b0;
    cw = 1'b0;
    if (exp_q.size() > 0 && int'(exp_q[0][31:0]) == cyc) begin
      st = 1'b1;
      cw = exp_q[0][32];
      void'(exp_q.pop_front());
    end
    if (!rst) begin
      m_pos = 0; m_up = 1'b1; m_has = 1'b0; m_cnten = 1'b0;
      m_dirch = 1'b0; m_eq = 1'b0; m_disp = 1'b0;
      exp_q.delete();
    end else begin
      m_eq   = (m_pos == code_of(bus.sel));
      m_disp = ~bus.blank;
      if (bus.clrCount) begin
        m_pos = 0; m_up = 1'b1; m_has = 1'b0; m_cnten = 1'b0; m_dirch = 1'b0;
      end else if (st) begin
        m_cnten = 1'b1;
        m_dirch = !bus.countEn && m_has && (cw != m_up);
        m_pos   = cw ? (m_pos + 1) % 40 : (m_pos + 39) % 40;
        m_up    = cw;
        if (!bus.countEn) m_has = 1'b1;
      end else begin
        m_cnten = 1'b0; m_dirch = 1'b0;
      end
    end
    #1;
    if (bus.cnten) n_cnten++;
    chk("cyc_cnten",   int'(bus.cnten),   int'(m_cnten));
    chk("cyc_up",      int'(bus.up),      int'(m_up));
    chk("cyc_dirch",   int'(bus.dirch),   int'(m_dirch));
    chk("cyc_eq",      int'(bus.eq),      int'(m_eq));
    chk("cyc_pos",     int'(bus.pos),     m_pos);
    chk("cyc_disp_on", int'(bus.disp_on), int'(m_disp));
  end

  // ---------------- driver tasks ----------------
  // Raise qa with direction on qb; return 2 units after the acceptance edge.
  task automatic step_accept(input logic cw);
    @(negedge clk);
    bus.qb = ~cw;
    bus.qa = 1'b1;
    exp_q.push_back({cw, 32'(cyc + LAT)});
    repeat (LAT) @(posedge clk);
    #2;
  endtask

  task automatic step_release();
    @(negedge clk);
    bus.qa = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic step(input logic cw);
    step_accept(cw);
    step_release();
  endtask

  task automatic clear();
    @(negedge clk);
    bus.clrCount = 1'b1;
    @(negedge clk);
    bus.clrCount = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    bus.qa = 1'b0; bus.qb = 1'b0; bus.countEn = 1'b1; bus.clrCount = 1'b0;
    bus.sel = 2'd0; bus.blank = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_pos",   int'(bus.pos), 0);
    chk("rst_up",    int'(bus.up), 1);
    chk("rst_cnten", int'(bus.cnten), 0);
    chk("rst_eq",    int'(bus.eq), 0);
    chk("rst_disp",  int'(bus.disp_on), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: three CW steps in free mode
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("t1_pulses", n_cnten, 3);
    chk("t1_pos",    int'(bus.pos), 3);
    chk("t1_up",     int'(bus.up), 1);

    // 2: dial to 10 with history, then reverse
    clear();
    bus.countEn = 1'b0; bus.sel = 2'd0;
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("t2_pos10", int'(bus.pos), 10);
    chk("t2_eq10",  int'(bus.eq), 1);
    step_accept(1'b0);
    chk("t2_dirch", int'(bus.dirch), 1);
    chk("t2_eq",    int'(bus.eq), 1);
    chk("t2_pos",   int'(bus.pos), 9);
    chk("t2_up",    int'(bus.up), 0);
    @(posedge clk); #2;
    chk("t2_dirch_pulse", int'(bus.dirch), 0);
    step_release();

    // 3: wrap both ways in free mode
    clear();
    bus.countEn = 1'b1;
    step_accept(1'b0);
    chk("t3_pos39", int'(bus.pos), 39);
    step_release();
    step_accept(1'b1);
    chk("t3_pos0",  int'(bus.pos), 0);
    chk("t3_dirch", int'(bus.dirch), 0);
    step_release();

    // 4: clear coincident with a step, then history is empty
    bus.countEn = 1'b0;
    step(1'b1);
    step(1'b0);
    @(negedge clk);
    bus.qb = 1'b0; bus.qa = 1'b1;
    exp_q.push_back({1'b1, 32'(cyc + LAT)});
    repeat (LAT - 1) @(negedge clk);
    bus.clrCount = 1'b1;
    @(posedge clk); #2;
    chk("t4_pos",   int'(bus.pos), 0);
    chk("t4_up",    int'(bus.up), 1);
    chk("t4_cnten", int'(bus.cnten), 0);
    @(negedge clk);
    bus.clrCount = 1'b0;
    bus.qa = 1'b0;
    repeat (HOLD) @(negedge clk);
    step_accept(1'b0);
    chk("t4_dirch", int'(bus.dirch), 0);
    chk("t4_cnten_ccw", int'(bus.cnten), 1);
    chk("t4_pos39", int'(bus.pos), 39);
    step_release();

    // 5: sel=3 forces eq low, sel=1 compares to 25, blank
    clear();
    bus.countEn = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1);
    @(negedge clk); bus.sel = 2'd3;
    repeat (2) @(negedge clk);
    chk("t5_eq_none", int'(bus.eq), 0);
    for (int i = 0; i < 15; i++) step(1'b1);
    chk("t5_pos25", int'(bus.pos), 25);
    @(negedge clk); bus.sel = 2'd1;
    @(posedge clk); #2;
    chk("t5_eq_d1", int'(bus.eq), 1);
    @(negedge clk); bus.blank = 1'b1;
    @(posedge clk); #2;
    chk("t5_disp_off", int'(bus.disp_on), 0);
    @(negedge clk); bus.blank = 1'b0;
    @(posedge clk); #2;
    chk("t5_disp_on", int'(bus.disp_on), 1);

    // Mid-operation reset clears history
    bus.countEn = 1'b0;
    step(1'b1);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mr_pos", int'(bus.pos), 0);
    chk("mr_up",  int'(bus.up), 1);
    repeat (2) @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    step_accept(1'b0);
    chk("mr_dirch", int'(bus.dirch), 0);
    chk("mr_pos39", int'(bus.pos), 39);
    step_release();

`ifdef SAFE_DIAL_DEBOUNCE_EN
    // 6: short glitch is filtered, long pulse steps at 11 clk
    lat = n_cnten;
    @(negedge clk); bus.qb = 1'b0; bus.qa = 1'b1;
    repeat (5) @(negedge clk);
    bus.qa = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_glitch", n_cnten, lat);
    bus.qa = 1'b1;
    exp_q.push_back({1'b1, 32'(cyc + LAT)});
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #2;
      if (bus.cnten) begin
        lat = k;
        break;
      end
    end
    chk("t6_latency", lat, 11);
    repeat (20 - 11) @(negedge clk);
    bus.qa = 1'b0;
    repeat (HOLD) @(negedge clk);
`else
    lat = 0;
`endif

    repeat (4) @(negedge clk);
    chk("end_no_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
